// File: rtl/shr_result_stage.sv
// Registered result FIFO behind the 8-bit logical shift-right unit; stores result plus zero/sticky flags.
// Latency 1 cycle push-to-out_valid; in_ready = not full, driven from registered count only. Optional sticky via SHR_STICKY_EN.
module shr_result_stage #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [3:0]               in_shift,
   input  logic [WIDTH-1:0]         in_result,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_result,
   output logic                     out_zero,
   output logic                     out_sticky,
   output logic [$clog2(DEPTH):0]   out_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   generate
      if (WIDTH != 8) begin : g_bad_width
         $error("shr_result_stage: WIDTH must be 8");
      end
      if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("shr_result_stage: DEPTH must be a power of two in 2..16");
      end
   endgenerate

   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_result [DEPTH];
   logic             r_zero   [DEPTH];
   logic             w_push;
   logic             w_pop;

   assign in_ready  = (r_count != CW'(DEPTH));
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

`ifdef SHR_STICKY_EN
   logic             r_sticky [DEPTH];
   logic [WIDTH-1:0] w_mask;
   logic             w_sticky;

   // Shifts of 8+ lose every operand bit; shift 0 gives an all-zero mask.
   assign w_mask = (WIDTH'(1) << in_shift[2:0]) - WIDTH'(1);

   always_comb begin
      w_sticky = 1'b0;
      if (in_shift[3]) w_sticky = |in_a;
      else             w_sticky = |(in_a & w_mask);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_sticky[i] <= 1'b0;
      end else if (w_push) begin
         r_sticky[r_wr_ptr] <= w_sticky;
      end
   end

   assign out_sticky = r_sticky[r_rd_ptr];
`else
   logic w_unused_inputs;
   assign w_unused_inputs = ^{in_a, in_shift};
   assign out_sticky      = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_result[i] <= '0;
            r_zero[i]   <= 1'b0;
         end
      end else begin
         if (w_push) begin
            r_result[r_wr_ptr] <= in_result;
            r_zero[r_wr_ptr]   <= (in_result == '0);
            r_wr_ptr           <= r_wr_ptr + AW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign out_result = r_result[r_rd_ptr];
   assign out_zero   = r_zero[r_rd_ptr];
   assign out_count  = r_count;

endmodule

// File: tb/tb_shr_result_stage.sv
// Self-checking bench for shr_result_stage against a queue-based model.
module tb_shr_result_stage;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_a = '0;
   logic [3:0] in_shift = '0;
   logic [7:0] in_result = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_result;
   logic       out_zero;
   logic       out_sticky;
   logic [2:0] out_count;

   int checks = 0;
   int passes = 0;

   typedef struct {
      logic [7:0] result;
      logic       zero;
      logic       sticky;
   } entry_t;

   entry_t q[$];

   shr_result_stage #(.DEPTH(DEPTH), .WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_shift(in_shift), .in_result(in_result),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_zero(out_zero), .out_sticky(out_sticky),
      .out_count(out_count)
   );

   always #5 clk = ~clk;

   // A bit is lost whenever the operand is not a multiple of 2**shift.
   function automatic entry_t mk(input logic [7:0] a, input logic [3:0] s, input logic [7:0] res);
      entry_t e;
      int ai = a;
      int si = s;
      e.result = res;
      e.zero   = (res == 8'h00);
`ifdef SHR_STICKY_EN
      e.sticky = ((ai % (1 << si)) != 0);
`else
      e.sticky = (ai < 0);
`endif
      return e;
   endfunction

   task automatic drive(input logic v, input logic [7:0] a, input logic [3:0] s,
                        input logic [7:0] res, input logic ordy);
      in_valid = v; in_a = a; in_shift = s; in_result = res; out_ready = ordy;
   endtask

   // Advance one edge and update the model from the inputs presented at that edge.
   task automatic step();
      bit acc, pop;
      entry_t e;
      acc = in_valid && (q.size() < DEPTH);
      pop = (q.size() > 0) && out_ready;
      e = mk(in_a, in_shift, in_result);
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3;
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", out_valid); else passes++;
      checks++; if (out_count !== 3'd0) $display("FAIL reset_count got %0d exp 0", out_count); else passes++;
      checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %0b exp 1", in_ready); else passes++;
      checks++; if (out_result !== 8'h00) $display("FAIL reset_result got %h exp 00", out_result); else passes++;
      checks++; if (out_zero !== 1'b0) $display("FAIL reset_zero got %0b exp 0", out_zero); else passes++;
      checks++; if (out_sticky !== 1'b0) $display("FAIL reset_sticky got %0b exp 0", out_sticky); else passes++;
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      logic exp_st;
`ifdef SHR_STICKY_EN
      exp_st = 1'b1;
`else
      exp_st = 1'b0;
`endif
      drive(1'b1, 8'hB5, 4'd3, 8'h16, 1'b0);
      step();
      drive(1'b0, 8'h00, 4'd0, 8'h00, 1'b0);
      checks++; if (out_valid !== 1'b1) $display("FAIL single_valid got %0b exp 1", out_valid); else passes++;
      checks++; if (out_result !== 8'h16) $display("FAIL single_result got %h exp 16", out_result); else passes++;
      checks++; if (out_zero !== 1'b0) $display("FAIL single_zero got %0b exp 0", out_zero); else passes++;
      checks++; if (out_sticky !== exp_st) $display("FAIL single_sticky got %0b exp %0b", out_sticky, exp_st); else passes++;
      checks++; if (out_count !== 3'd1) $display("FAIL single_count got %0d exp 1", out_count); else passes++;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) $display("FAIL single_pop_valid got %0b exp 0", out_valid); else passes++;
   endtask

   task automatic test_flags();
      logic [7:0] ta [3] = '{8'hF0, 8'h01, 8'h80};
      logic [3:0] ts [3] = '{4'd4, 4'd9, 4'd0};
      logic [7:0] tr [3] = '{8'h0F, 8'h00, 8'h80};
      logic       tz [3] = '{1'b0, 1'b1, 1'b0};
      logic       tk [3];
`ifdef SHR_STICKY_EN
      tk = '{1'b0, 1'b1, 1'b0};
`else
      tk = '{1'b0, 1'b0, 1'b0};
`endif
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, ta[i], ts[i], tr[i], 1'b0);
         step();
         drive(1'b0, 8'h00, 4'd0, 8'h00, 1'b0);
         checks++; if (out_result !== tr[i]) $display("FAIL flags%0d_result got %h exp %h", i, out_result, tr[i]); else passes++;
         checks++; if (out_zero !== tz[i]) $display("FAIL flags%0d_zero got %0b exp %0b", i, out_zero, tz[i]); else passes++;
         checks++; if (out_sticky !== tk[i]) $display("FAIL flags%0d_sticky got %0b exp %0b", i, out_sticky, tk[i]); else passes++;
         out_ready = 1'b1;
         step();
      end
      drive(1'b0, 8'h00, 4'd0, 8'h00, 1'b0);
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 8'(8'h11 * (i + 1)), 4'(i), 8'(8'h11 * (i + 1)) >> i, 1'b0);
         step();
      end
      drive(1'b0, 8'h00, 4'd0, 8'h00, 1'b0);
      checks++; if (in_ready !== 1'b0) $display("FAIL fill_ready got %0b exp 0", in_ready); else passes++;
      checks++; if (out_count !== 3'd4) $display("FAIL fill_count got %0d exp 4", out_count); else passes++;
      drive(1'b1, 8'hEE, 4'd1, 8'h77, 1'b0);
      step();
      checks++; if (out_count !== 3'd4) $display("FAIL fill_ignored_count got %0d exp 4", out_count); else passes++;
      drive(1'b0, 8'h00, 4'd0, 8'h00, 1'b1);
      step();
      out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1) $display("FAIL fill_ready_after_pop got %0b exp 1", in_ready); else passes++;
      checks++; if (out_count !== 3'd3) $display("FAIL fill_count_after_pop got %0d exp 3", out_count); else passes++;
      while (q.size() > 0) begin
         checks++; if (out_result !== q[0].result) $display("FAIL fill_order got %h exp %h", out_result, q[0].result); else passes++;
         out_ready = 1'b1;
         step();
      end
      checks++; if (out_valid !== 1'b0) $display("FAIL fill_drained got %0b exp 0", out_valid); else passes++;
      out_ready = 1'b0;
   endtask

   task automatic test_wrap();
      drive(1'b1, 8'hA0, 4'd2, 8'h28, 1'b0);
      step();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 8'(i * 23 + 5), 4'(i), 8'(i * 23 + 5) >> i, 1'b1);
         checks++; if (out_count !== 3'd1) $display("FAIL wrap%0d_count got %0d exp 1", i, out_count); else passes++;
         checks++; if (out_result !== q[0].result) $display("FAIL wrap%0d_result got %h exp %h", i, out_result, q[0].result); else passes++;
         step();
      end
      drive(1'b0, 8'h00, 4'd0, 8'h00, 1'b1);
      checks++; if (out_result !== q[0].result) $display("FAIL wrap_last got %h exp %h", out_result, q[0].result); else passes++;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'(8'h31 + i), 4'd1, 8'(8'h31 + i) >> 1, 1'b0);
         step();
      end
      drive(1'b0, 8'h00, 4'd0, 8'h00, 1'b0);
      checks++; if (out_count !== 3'd3) $display("FAIL mid_pre_count got %0d exp 3", out_count); else passes++;
      #2 rst = 1'b1;
      #1;
      q.delete();
      checks++; if (out_valid !== 1'b0) $display("FAIL mid_valid got %0b exp 0", out_valid); else passes++;
      checks++; if (out_count !== 3'd0) $display("FAIL mid_count got %0d exp 0", out_count); else passes++;
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1'b1, 8'h6C, 4'd2, 8'h1B, 1'b0);
      step();
      drive(1'b0, 8'h00, 4'd0, 8'h00, 1'b0);
      checks++; if (out_count !== 3'd1) $display("FAIL mid_new_count got %0d exp 1", out_count); else passes++;
      checks++; if (out_result !== 8'h1B) $display("FAIL mid_new_result got %h exp 1b", out_result); else passes++;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [7:0] a, r;
      logic [3:0] s;
      for (int i = 0; i < 400; i++) begin
         a = 8'($urandom);
         s = 4'($urandom_range(0, 15));
         r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (a >> s);
         drive(1'($urandom_range(0, 3) != 0), a, s, r, 1'($urandom_range(0, 2) != 0));
         checks++; if (in_ready !== (q.size() < DEPTH)) $display("FAIL rnd%0d_ready got %0b exp %0b", i, in_ready, q.size() < DEPTH); else passes++;
         checks++; if (out_count !== 3'(q.size())) $display("FAIL rnd%0d_count got %0d exp %0d", i, out_count, q.size()); else passes++;
         checks++; if (out_valid !== (q.size() > 0)) $display("FAIL rnd%0d_valid got %0b exp %0b", i, out_valid, q.size() > 0); else passes++;
         if (q.size() > 0) begin
            checks++; if (out_result !== q[0].result) $display("FAIL rnd%0d_result got %h exp %h", i, out_result, q[0].result); else passes++;
            checks++; if (out_zero !== q[0].zero) $display("FAIL rnd%0d_zero got %0b exp %0b", i, out_zero, q[0].zero); else passes++;
            checks++; if (out_sticky !== q[0].sticky) $display("FAIL rnd%0d_sticky got %0b exp %0b", i, out_sticky, q[0].sticky); else passes++;
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_flags();
      test_fill();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
